accu_readout: RTL and testbench
===============================

# accu_readout

Reads out the I/Q accumulators at the end of each measurement window and sends them as one AXI-Stream frame. It sits downstream of the accumulator trigger logic. It counts the accumulated samples while `accu_enable` is high, captures count, I sum and Q sum on the `done_samples_valid` pulse, and serialises them to the PS-side DMA/FIFO.

## Interface
- `AXIS_TDATA_WIDTH`, 32: output word width; also the header width.
- `ACC_WIDTH`, 64: width of each accumulator. Must be an integer multiple of `AXIS_TDATA_WIDTH`. `W = ACC_WIDTH/AXIS_TDATA_WIDTH`.
- `aclk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `accu_enable`  in  1  high while the accumulators integrate.
- `done_samples_valid`  in  1  single-cycle pulse: window closed, accumulators are final.
- `accu_i`  in  ACC_WIDTH  I accumulator, signed; valid when `done_samples_valid` is high.
- `accu_q`  in  ACC_WIDTH  Q accumulator, signed; valid when `done_samples_valid` is high.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  frame word.
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tlast`  out  1  last word of frame.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  high from capture until the last word is accepted.

## Operation
- **Sample counter** (`AXIS_TDATA_WIDTH-1` bits, unsigned).
  - Cleared to 0 on a registered rising edge of `accu_enable`.
  - In that edge cycle it loads 1 instead of incrementing.
  - Afterwards it increments by 1 each cycle `accu_enable` is high.
  - It saturates at all-ones and never wraps.
  - It holds its value while `accu_enable` is low.
- **Overrun flag** (internal, sticky).
  - Set when `done_samples_valid` arrives while `busy` and the frame's final handshake is not completing in that cycle.
  - On every capture, its value is copied into the captured header, then it is cleared.
- **Capture.** When `done_samples_valid` is high and the block is not busy, latch:
  - header = {overrun, sample_count};
  - `accu_i`;
  - `accu_q`.
- **Frame order.** 1 + 2W words:
  - header (bit MSB = overrun, remaining bits = count);
  - I words, least-significant word first;
  - Q words, least-significant word first.
  - `m_axis_tlast` is high on the final Q word only.
- **FSM.**
  - IDLE → HDR on capture.
  - HDR → IWORDS on handshake.
  - IWORDS → QWORDS after W handshakes.
  - QWORDS → IDLE after W handshakes.
  - QWORDS → HDR directly if `done_samples_valid` coincides with the final handshake; this is a new capture, not an overrun.
  - The word index counter runs 0..W-1 and resets on each section change.
- **Drop.** A `done_samples_valid` pulse received while busy (except the coincidence case above) is discarded: its data is not captured, and only the overrun flag is set.
- `busy` = state ≠ IDLE.

## Timing
- Reset values:
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `busy` = 0;
  - sample counter = 0, overrun = 0;
  - state IDLE.
- Capture latency: pulse at cycle N gives `m_axis_tvalid` = 1 with the header at cycle N+1.
- Throughput: with `tready` held high, one word per cycle; a frame takes 1+2W cycles.
- AXI-Stream rules:
  - Once `tvalid` is high, `tdata`, `tlast` and `tvalid` hold until `tvalid && tready`.
  - `tvalid` never depends combinationally on `tready`.
  - All outputs are registered.
- Coincidence case: the next header appears in the cycle after the final Q handshake, so `tvalid` has no gap.
- Counter timing:
  - `accu_enable` falls one cycle before `done_samples_valid`; the count is stable at capture.
  - An `accu_enable` rising edge during a frame resets the counter but does not affect the latched header.
- Reset mid-frame returns immediately to the reset values. The partial frame is abandoned; no `tlast` is emitted.

## Test plan
- **Basic frame.** Defaults (W=2); `accu_enable` high for 100 cycles; pulse with I=0x0000_0001_8000_0000, Q=-1; `tready`=1 → five words:
  - 0x0000_0064;
  - 0x8000_0000;
  - 0x0000_0001;
  - 0xFFFF_FFFF;
  - 0xFFFF_FFFF with `tlast`.
- **Backpressure.** Same stimulus, `tready` toggling 1-0-0-1 pseudo-randomly → identical word sequence, `tdata` stable during every stall, exactly one `tlast`.
- **Overrun.** Hold `tready`=0 after the header is presented; send a second pulse → second pulse dropped. The next frame's header has MSB=1; the following frame's header has MSB=0.
- **Coincidence.** `tready`=1; assert the second pulse in the cycle of the final Q handshake → back-to-back frames, 10 consecutive valid words, both headers with MSB=0.
- **Saturation.** AXIS_TDATA_WIDTH=8, `accu_enable` high for 200 cycles → header = 0x7F.
- **Async reset mid-frame.** Drop `rst` between clock edges during the I words:
  - `tvalid` and `busy` go low without waiting for a clock edge;
  - after release, a new pulse produces a complete, correct frame.

Source files
------------

// File: rtl/accu_readout.sv
// I/Q accumulator readout: counts integrated samples, captures count and sums
// at the end of a window and streams them as one AXI-Stream frame.
module accu_readout #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ACC_WIDTH        = 64
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic                          accu_enable,
    input  logic                          done_samples_valid,
    input  logic [ACC_WIDTH-1:0]          accu_i,
    input  logic [ACC_WIDTH-1:0]          accu_q,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          busy
);

    localparam int W     = ACC_WIDTH / AXIS_TDATA_WIDTH;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int CNT_W = AXIS_TDATA_WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_I    = 2'd2;
    localparam logic [1:0] S_Q    = 2'd3;

    function automatic logic [AXIS_TDATA_WIDTH-1:0] word_of(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [IDX_W-1:0]     k
    );
        return acc[int'(k)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
    endfunction

    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          en_prev_q, en_prev_d;
    logic                          ovr_q, ovr_d;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                          tvalid_q, tvalid_d;
    logic                          tlast_q, tlast_d;
    logic [ACC_WIDTH-1:0]          acc_i_q, acc_i_d;
    logic [ACC_WIDTH-1:0]          acc_q_q, acc_q_d;

    logic                          hs;
    logic                          last_word;
    logic                          final_hs;
    logic                          capture;
    logic                          drop;
    logic [IDX_W-1:0]              nidx;
    logic [AXIS_TDATA_WIDTH-1:0]   header;

    always_comb begin
        hs        = tvalid_q && m_axis_tready;
        last_word = (idx_q == IDX_W'(W - 1));
        nidx      = idx_q + IDX_W'(1);
        final_hs  = (state_q == S_Q) && hs && last_word;
        // A pulse landing on the final handshake starts the next frame rather than overrunning.
        capture   = done_samples_valid && ((state_q == S_IDLE) || final_hs);
        drop      = done_samples_valid && (state_q != S_IDLE) && !final_hs;
        header    = {ovr_q, cnt_q};
    end

    always_comb begin
        en_prev_d = accu_enable;
        cnt_d     = cnt_q;
        if (accu_enable && !en_prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (accu_enable && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        ovr_d = ovr_q;
        if (capture) begin
            ovr_d = 1'b0;
        end else if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;

        if (capture) begin
            acc_i_d = accu_i;
            acc_q_d = accu_q;
        end

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d  = S_HDR;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = header;
                    tlast_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d = S_I;
                    idx_d   = '0;
                    tdata_d = word_of(acc_i_q, IDX_W'(0));
                    tlast_d = 1'b0;
                end
            end
            S_I: begin
                if (hs) begin
                    if (last_word) begin
                        state_d = S_Q;
                        idx_d   = '0;
                        tdata_d = word_of(acc_q_q, IDX_W'(0));
                        tlast_d = (W == 1);
                    end else begin
                        idx_d   = nidx;
                        tdata_d = word_of(acc_i_q, nidx);
                    end
                end
            end
            S_Q: begin
                if (hs) begin
                    if (last_word) begin
                        idx_d   = '0;
                        tlast_d = 1'b0;
                        if (capture) begin
                            state_d = S_HDR;
                            tdata_d = header;
                        end else begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            tdata_d  = '0;
                        end
                    end else begin
                        idx_d   = nidx;
                        tdata_d = word_of(acc_q_q, nidx);
                        tlast_d = (nidx == IDX_W'(W - 1));
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
            ovr_q     <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            en_prev_q <= en_prev_d;
            ovr_q     <= ovr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    // Captured sums are only read while a frame is in flight, so they need no reset.
    always_ff @(posedge aclk) begin
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_accu_readout.sv
// Directed bench for accu_readout with a word scoreboard checked on every valid cycle.
module tb_accu_readout;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        rst = 1'b0;
    logic        accu_enable = 1'b0;
    logic        done = 1'b0;
    logic [63:0] accu_i = '0;
    logic [63:0] accu_q = '0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready = 1'b1;
    logic        busy;

    logic        en8 = 1'b0;
    logic        done8 = 1'b0;
    logic [15:0] acc8 = 16'h1234;
    logic [7:0]  tdata8;
    logic        tvalid8;
    logic        tlast8;
    logic        tready8 = 1'b0;
    logic        busy8;

    accu_readout #(.AXIS_TDATA_WIDTH(32), .ACC_WIDTH(64)) dut (
        .aclk(aclk), .rst(rst), .accu_enable(accu_enable),
        .done_samples_valid(done), .accu_i(accu_i), .accu_q(accu_q),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tready(tready), .busy(busy)
    );

    accu_readout #(.AXIS_TDATA_WIDTH(8), .ACC_WIDTH(16)) dut8 (
        .aclk(aclk), .rst(rst), .accu_enable(en8),
        .done_samples_valid(done8), .accu_i(acc8), .accu_q(acc8),
        .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tlast(tlast8),
        .m_axis_tready(tready8), .busy(busy8)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t sb[$];
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int lasts_seen = 0;
    int exp_lasts = 0;
    int vrun = 0;
    int vrun_max = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every presented word must match the scoreboard head, which also proves stall stability.
    always @(negedge aclk) begin
        if (rst === 1'b1) begin
            if (tvalid === 1'b1) begin
                vrun++;
                if (vrun > vrun_max) vrun_max = vrun;
                if (sb.size() == 0) begin
                    chk("unexpected_word_valid", 64'(tvalid), 64'd0);
                end else begin
                    chk("tdata", 64'(tdata), 64'(sb[0].d));
                    chk("tlast", 64'(tlast), 64'(sb[0].l));
                    if (tready === 1'b1) begin
                        void'(sb.pop_front());
                        if (tlast === 1'b1) lasts_seen++;
                    end
                end
            end else begin
                vrun = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic window(input int n);
        accu_enable = 1'b1;
        step(n);
        accu_enable = 1'b0;
        step(1);
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        sb.push_back(w);
    endtask

    task automatic push_frame(input logic ovr, input int cnt, input logic [63:0] i, input logic [63:0] q);
        logic [30:0] c;
        c = cnt[30:0];
        push_word({ovr, c}, 1'b0);
        push_word(i[31:0], 1'b0);
        push_word(i[63:32], 1'b0);
        push_word(q[31:0], 1'b0);
        push_word(q[63:32], 1'b1);
        exp_lasts++;
    endtask

    task automatic pulse(input logic ovr, input int cnt, input logic [63:0] i,
                         input logic [63:0] q, input bit expect_frame);
        done   = 1'b1;
        accu_i = i;
        accu_q = q;
        if (expect_frame) push_frame(ovr, cnt, i, q);
        step(1);
        done = 1'b0;
    endtask

    task automatic wait_idle(input bit bp, input string tag);
        int n;
        n = 0;
        while ((busy === 1'b1 || sb.size() != 0) && n < 2000) begin
            if (bp) tready = 1'($urandom_range(0, 1));
            step(1);
            n++;
        end
        tready = 1'b1;
        chk({tag, "_timeout"}, 64'(n < 2000), 64'd1);
        chk({tag, "_tlast_count"}, 64'(lasts_seen), 64'(exp_lasts));
    endtask

    initial begin
        step(2);
        chk("reset_tvalid", 64'(tvalid), 64'd0);
        chk("reset_tlast", 64'(tlast), 64'd0);
        chk("reset_tdata", 64'(tdata), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_tvalid8", 64'(tvalid8), 64'd0);
        rst = 1'b1;
        step(2);

        // Narrow instance: 7-bit counter saturates at 0x7F
        en8 = 1'b1;
        step(200);
        en8 = 1'b0;
        step(1);
        done8 = 1'b1;
        step(1);
        done8 = 1'b0;
        chk("sat_tvalid", 64'(tvalid8), 64'd1);
        chk("sat_header", 64'(tdata8), 64'h7F);

        // Basic frame
        tready = 1'b1;
        window(100);
        pulse(1'b0, 100, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("cap_latency_tvalid", 64'(tvalid), 64'd1);
        chk("cap_latency_busy", 64'(busy), 64'd1);
        wait_idle(1'b0, "basic");

        // Backpressure
        window(100);
        pulse(1'b0, 100, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle(1'b1, "backpressure");

        // Overrun: stall on header, second pulse dropped
        tready = 1'b0;
        window(50);
        pulse(1'b0, 50, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
        step(3);
        chk("ovr_still_busy", 64'(busy), 64'd1);
        pulse(1'b0, 0, 64'hDEAD_BEEF_DEAD_BEEF, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
        step(2);
        tready = 1'b1;
        wait_idle(1'b0, "ovr_first");
        window(20);
        pulse(1'b1, 20, 64'h0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        wait_idle(1'b0, "ovr_flagged");
        window(30);
        pulse(1'b0, 30, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle(1'b0, "ovr_cleared");

        // Coincidence: second pulse on the final Q handshake
        tready = 1'b1;
        vrun_max = 0;
        window(10);
        pulse(1'b0, 10, 64'hAAAA_0001_BBBB_0002, 64'hCCCC_0003_DDDD_0004, 1'b1);
        step(4);
        pulse(1'b0, 10, 64'h0102_0304_0506_0708, 64'h090A_0B0C_0D0E_0F10, 1'b1);
        wait_idle(1'b0, "coincide");
        chk("coincide_valid_run", 64'(vrun_max), 64'd10);

        // Async reset while I words are on the bus
        window(40);
        pulse(1'b0, 40, 64'h0000_0040_0000_0041, 64'h0000_0042_0000_0043, 1'b1);
        step(1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tvalid", 64'(tvalid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_tlast", 64'(tlast), 64'd0);
        chk("arst_tdata", 64'(tdata), 64'd0);
        sb.delete();
        exp_lasts--;
        step(2);
        rst = 1'b1;
        step(1);
        window(25);
        pulse(1'b0, 25, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 1'b1);
        wait_idle(1'b0, "after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
